// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB, bit-serial shifts (one bit per cycle),
// with a valid/ready handshake on both the request and the result side.
module alu_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              ctrl_q, ctrl_d;
  logic signed [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]          count_q, count_d;
  logic                    illegal_q, illegal_d;
  logic [SHW-1:0]          shamt;

  // One-bit shift step; SRA replicates the sign bit of the running result.
  function automatic logic signed [WIDTH-1:0] shift_one(input logic signed [WIDTH-1:0] v,
                                                        input logic [3:0] op);
    case (op)
      OP_SLL:  shift_one = v <<< 1;
      OP_SRA:  shift_one = v >>> 1;
      default: shift_one = $signed({1'b0, v[WIDTH-1:1]});
    endcase
  endfunction

  function automatic logic signed [WIDTH-1:0] logic_arith(input logic [3:0] op,
                                                          input logic signed [WIDTH-1:0] a,
                                                          input logic signed [WIDTH-1:0] b);
    case (op)
      OP_AND:  logic_arith = a & b;
      OP_OR:   logic_arith = a | b;
      OP_ADD:  logic_arith = a + b;
      default: logic_arith = a - b;
    endcase
  endfunction

  assign shamt = op_b[SHW-1:0];

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    result_d  = result_q;
    count_d   = count_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ctrl_d    = alu_ctrl;
          illegal_d = 1'b0;
          count_d   = '0;
          state_d   = DONE;
          case (alu_ctrl)
            OP_AND, OP_OR, OP_ADD, OP_SUB:
              result_d = logic_arith(alu_ctrl, $signed(op_a), $signed(op_b));
            OP_SLL, OP_SRL, OP_SRA: begin
              result_d = $signed(op_a);
              if (shamt != '0) begin
                count_d = shamt;
                state_d = SHIFT;
              end
            end
            default: begin
              result_d  = '0;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      SHIFT: begin
        result_d = shift_one(result_q, ctrl_q);
        count_d  = count_q - SHW'(1);
        if (count_q == SHW'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ctrl_q    <= OP_AND;
      result_q  <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      result_q  <= result_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: hand-computed vectors, latency, backpressure and reset abort.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_exec #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for out_valid; returns edges counted from accept.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    chk("in_ready_before_issue", in_ready, 1'b1);
    alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_ill, input int exp_lat);
    int lat;
    issue(c, a, b, lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_zero"}, zero, exp_res == 32'h0);
    chk({tag, "_ill"}, illegal, exp_ill);
    step();
    chk({tag, "_done_valid"}, out_valid, 1'b0);
    chk({tag, "_done_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    logic seen_valid;
    rst = 1'b1; in_valid = 1'b0; alu_ctrl = 4'h0; op_a = '0; op_b = '0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", zero, 1'b1);
    chk("rst_illegal", illegal, 1'b0);

    run_op("add",     4'b0010, 32'h5,          32'h3,          32'h8,          1'b0, 1);
    run_op("sub_eq",  4'b0110, 32'h1234_5678,  32'h1234_5678,  32'h0,          1'b0, 1);
    run_op("sub_wrap",4'b0110, 32'h0,          32'h1,          32'hFFFF_FFFF,  1'b0, 1);
    run_op("sra4",    4'b0101, 32'h8000_0000,  32'h4,          32'hF800_0000,  1'b0, 5);
    run_op("srl4",    4'b0100, 32'h8000_0000,  32'h4,          32'h0800_0000,  1'b0, 5);
    run_op("sll31",   4'b0011, 32'h1,          32'd31,         32'h8000_0000,  1'b0, 32);
    run_op("sll_sh0", 4'b0011, 32'hDEAD_BEEF,  32'h20,         32'hDEAD_BEEF,  1'b0, 1);
    run_op("or_min",  4'b0001, 32'hA000_0001,  32'h0500_0000,  32'hA500_0001,  1'b0, 1);
    run_op("illegal", 4'b1111, 32'h1234,       32'h5678,       32'h0,          1'b1, 1);
    run_op("or_after",4'b0001, 32'h0F,         32'hF0,         32'hFF,         1'b0, 1);

    // Backpressure: hold the AND result while a competing request is presented.
    out_ready = 1'b0;
    issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    chk("bp_lat", lat, 1);
    alu_ctrl = 4'b0010; op_a = 32'h1; op_b = 32'h1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_res", result, 32'hF000_F000);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_ready", in_ready, 1'b1);
    step();
    chk("bp_no_second", out_valid, 1'b0);
    chk("bp_res_kept", result, 32'hF000_F000);

    // Reset in the middle of a 20-bit SLL.
    alu_ctrl = 4'b0011; op_a = 32'h1; op_b = 32'd20; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 1; i < 8; i++) step();
    chk("mid_busy", in_ready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_zero", zero, 1'b1);
    seen_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (out_valid) seen_valid = 1'b1;
    end
    chk("mid_no_stale", seen_valid, 1'b0);

    run_op("post_rst_add", 4'b0010, 32'hFFFF_FFFF, 32'h2, 32'h1, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
